// File: rtl/regfile_write_queue.sv
// Write queue in front of the 8-entry register file write port.
// Buffers writeback requests, drains one per cycle, forwards pending data.
module regfile_write_queue #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 5,
  parameter  int DW    = 32,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [AW-1:0] i_req_addr,
  input  logic [DW-1:0] i_req_data,
  input  logic          i_hold,
  output logic [AW-1:0] o_a3,
  output logic          o_we3,
  output logic [DW-1:0] o_wd3,
  input  logic [AW-1:0] i_a1,
  input  logic [AW-1:0] i_a2,
  output logic          o_hit1,
  output logic          o_hit2,
  output logic [DW-1:0] o_fwd1,
  output logic [DW-1:0] o_fwd2,
  output logic [CW-1:0] o_count,
  output logic          o_badaddr
);

  logic [AW-1:0] r_mem_addr [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_a3;
  logic [DW-1:0] r_wd3;
  logic          r_we3;
  logic          r_bad;

  logic          w_ready;
  logic          w_acc;
  logic          w_bad;
  logic          w_push;
  logic          w_pop;
  logic [PW-1:0] w_idx;
  logic          w_hit1;
  logic          w_hit2;
  logic [DW-1:0] w_fwd1;
  logic [DW-1:0] w_fwd2;

  assign w_ready = i_rst_n & (r_count < CW'(DEPTH));
  assign w_acc   = i_req_valid & w_ready;
  assign w_bad   = |i_req_addr[AW-1:3];
  assign w_push  = w_acc & ~w_bad;
  assign w_pop   = ~i_hold & (r_count != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_addr[i] <= '0;
        r_mem_data[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_we3   <= 1'b0;
      r_a3    <= '0;
      r_wd3   <= '0;
      r_bad   <= 1'b0;
    end else begin
      r_bad <= w_acc & w_bad;
      if (w_push) begin
        r_mem_addr[r_wptr] <= i_req_addr;
        r_mem_data[r_wptr] <= i_req_data;
        r_wptr             <= r_wptr + PW'(1);
      end
      r_we3 <= w_pop;
      if (w_pop) begin
        r_a3   <= r_mem_addr[r_rptr];
        r_wd3  <= r_mem_data[r_rptr];
        r_rptr <= r_rptr + PW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk oldest to youngest so the youngest match is left standing.
  always_comb begin
    w_idx  = '0;
    w_hit1 = r_we3 && (r_a3 == i_a1);
    w_hit2 = r_we3 && (r_a3 == i_a2);
    w_fwd1 = w_hit1 ? r_wd3 : '0;
    w_fwd2 = w_hit2 ? r_wd3 : '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rptr + PW'(i);
      if (CW'(i) < r_count) begin
        if (r_mem_addr[w_idx] == i_a1) begin
          w_hit1 = 1'b1;
          w_fwd1 = r_mem_data[w_idx];
        end
        if (r_mem_addr[w_idx] == i_a2) begin
          w_hit2 = 1'b1;
          w_fwd2 = r_mem_data[w_idx];
        end
      end
    end
  end

  assign o_req_ready = w_ready;
  assign o_a3        = r_a3;
  assign o_we3       = r_we3;
  assign o_wd3       = r_wd3;
  assign o_hit1      = w_hit1;
  assign o_hit2      = w_hit2;
  assign o_fwd1      = w_fwd1;
  assign o_fwd2      = w_fwd2;
  assign o_count     = r_count;
  assign o_badaddr   = r_bad;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed bench for regfile_write_queue with a small register file model.
module tb_regfile_write_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr;
  logic [31:0] req_data;
  logic        hold;
  logic [4:0]  a3;
  logic        we3;
  logic [31:0] wd3;
  logic [4:0]  a1;
  logic [4:0]  a2;
  logic        hit1;
  logic        hit2;
  logic [31:0] fwd1;
  logic [31:0] fwd2;
  logic [2:0]  count;
  logic        badaddr;

  logic [31:0] rf [8];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (we3) rf[a3[2:0]] <= wd3;

  regfile_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_addr (req_addr),
    .i_req_data (req_data),
    .i_hold     (hold),
    .o_a3       (a3),
    .o_we3      (we3),
    .o_wd3      (wd3),
    .i_a1       (a1),
    .i_a2       (a2),
    .o_hit1     (hit1),
    .o_hit2     (hit2),
    .o_fwd1     (fwd1),
    .o_fwd2     (fwd2),
    .o_count    (count),
    .o_badaddr  (badaddr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_addr = '0;
    req_data = '0;
    hold = 1'b0;
    a1 = 5'd0;
    a2 = 5'd0;
    tick();
    tick();
    n_vec++;
    if (count !== 3'd0) begin
      n_err++; $display("FAIL reset_count got %0d want 0", count);
    end
    n_vec++;
    if ({we3, a3, wd3} !== 38'd0) begin
      n_err++; $display("FAIL reset_out got %b %h %h want 0", we3, a3, wd3);
    end
    n_vec++;
    if ({req_ready, badaddr, hit1, hit2} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_flags got %b want 0000",
               {req_ready, badaddr, hit1, hit2});
    end
    n_vec++;
    if ({fwd1, fwd2} !== 64'd0) begin
      n_err++; $display("FAIL reset_fwd got %h %h want 0", fwd1, fwd2);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_single_write();
    hold = 1'b0;
    req_valid = 1'b1;
    req_addr = 5'd3;
    req_data = 32'hDEADBEEF;
    tick();
    req_valid = 1'b0;
    n_vec++;
    if (count !== 3'd1 || we3 !== 1'b0) begin
      n_err++; $display("FAIL single_acc got c=%0d we=%b want 1 0", count, we3);
    end
    tick();
    a1 = 5'd3;
    #1;
    n_vec++;
    if ({we3, a3, wd3} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL single_wr got %b %0d %h want 1 3 deadbeef", we3, a3, wd3);
    end
    n_vec++;
    if (hit1 !== 1'b1 || fwd1 !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single_fwd got %b %h want 1 deadbeef", hit1, fwd1);
    end
    tick();
    n_vec++;
    if (we3 !== 1'b0 || rf[3] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL single_rf got we=%b rd1=%h want 0 deadbeef", we3, rf[3]);
    end
    n_vec++;
    if (hit1 !== 1'b0 || fwd1 !== 32'd0) begin
      n_err++; $display("FAIL single_nohit got %b %h want 0 0", hit1, fwd1);
    end
  endtask

  task automatic test_fill_held();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr = 5'(i + 1);
      req_data = 32'((i + 1) * 16);
      tick();
      n_vec++;
      if (we3 !== 1'b0) begin
        n_err++; $display("FAIL fill_we%0d got %b want 0", i, we3);
      end
    end
    req_valid = 1'b0;
    #1;
    n_vec++;
    if (count !== 3'd4 || req_ready !== 1'b0) begin
      n_err++; $display("FAIL fill_full got c=%0d rdy=%b want 4 0", count, req_ready);
    end
    hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if ({we3, a3, wd3} !== {1'b1, 5'(i + 1), 32'((i + 1) * 16)}) begin
        n_err++;
        $display("FAIL drain%0d got %b %0d %h want 1 %0d %h",
                 i, we3, a3, wd3, i + 1, (i + 1) * 16);
      end
    end
    n_vec++;
    if (count !== 3'd0) begin
      n_err++; $display("FAIL drain_count got %0d want 0", count);
    end
    tick();
    n_vec++;
    if (we3 !== 1'b0) begin
      n_err++; $display("FAIL drain_idle got %b want 0", we3);
    end
  endtask

  task automatic test_forward();
    hold = 1'b1;
    req_valid = 1'b1;
    req_addr = 5'd5;
    req_data = 32'h11;
    tick();
    req_data = 32'h22;
    tick();
    req_valid = 1'b0;
    a1 = 5'd5;
    a2 = 5'd6;
    #1;
    n_vec++;
    if ({hit1, fwd1} !== {1'b1, 32'h22}) begin
      n_err++; $display("FAIL fwd_young got %b %h want 1 22", hit1, fwd1);
    end
    n_vec++;
    if ({hit2, fwd2} !== {1'b0, 32'h0}) begin
      n_err++; $display("FAIL fwd_miss got %b %h want 0 0", hit2, fwd2);
    end
    hold = 1'b0;
    tick();
    n_vec++;
    if ({hit1, fwd1} !== {1'b1, 32'h22}) begin
      n_err++; $display("FAIL fwd_pop1 got %b %h want 1 22", hit1, fwd1);
    end
    tick();
    n_vec++;
    if ({we3, hit1, fwd1} !== {2'b11, 32'h22}) begin
      n_err++; $display("FAIL fwd_pop2 got %b %b %h want 1 1 22", we3, hit1, fwd1);
    end
    tick();
    n_vec++;
    if ({hit1, fwd1} !== {1'b0, 32'h0} || rf[5] !== 32'h22) begin
      n_err++; $display("FAIL fwd_done got %b %h rf=%h want 0 0 22", hit1, fwd1, rf[5]);
    end
  endtask

  task automatic test_bad_addr();
    hold = 1'b1;
    req_valid = 1'b1;
    req_addr = 5'd2;
    req_data = 32'hAA;
    tick();
    req_addr = 5'd9;
    req_data = 32'h99;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL bad_ready got %b want 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    n_vec++;
    if ({badaddr, count} !== {1'b1, 3'd1}) begin
      n_err++; $display("FAIL bad_pulse got %b c=%0d want 1 1", badaddr, count);
    end
    tick();
    n_vec++;
    if ({badaddr, count} !== {1'b0, 3'd1}) begin
      n_err++; $display("FAIL bad_clear got %b c=%0d want 0 1", badaddr, count);
    end
    hold = 1'b0;
    tick();
    n_vec++;
    if ({we3, a3, wd3} !== {1'b1, 5'd2, 32'hAA}) begin
      n_err++; $display("FAIL bad_drain got %b %0d %h want 1 2 aa", we3, a3, wd3);
    end
    req_valid = 1'b1;
    req_addr = 5'd16;
    tick();
    req_valid = 1'b0;
    n_vec++;
    if ({badaddr, count, we3} !== {1'b1, 3'd0, 1'b0}) begin
      n_err++; $display("FAIL bad_empty got %b c=%0d we=%b want 1 0 0", badaddr, count, we3);
    end
    tick();
    n_vec++;
    if ({badaddr, we3} !== 2'b00) begin
      n_err++; $display("FAIL bad_nowr got %b %b want 0 0", badaddr, we3);
    end
  endtask

  task automatic test_full_pop();
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr = 5'(i + 1);
      req_data = 32'h100 + 32'(i + 1);
      tick();
    end
    hold = 1'b0;
    req_addr = 5'd7;
    req_data = 32'h77;
    #1;
    n_vec++;
    if (req_ready !== 1'b0 || count !== 3'd4) begin
      n_err++; $display("FAIL full_ready got %b c=%0d want 0 4", req_ready, count);
    end
    tick();
    n_vec++;
    if ({count, req_ready, we3, a3} !== {3'd3, 2'b11, 5'd1}) begin
      n_err++;
      $display("FAIL full_pop got c=%0d rdy=%b we=%b a3=%0d want 3 1 1 1",
               count, req_ready, we3, a3);
    end
    tick();
    req_valid = 1'b0;
    n_vec++;
    if ({count, a3} !== {3'd3, 5'd2}) begin
      n_err++; $display("FAIL full_swap got c=%0d a3=%0d want 3 2", count, a3);
    end
    tick();
    tick();
    tick();
    n_vec++;
    if ({we3, a3, wd3, count} !== {1'b1, 5'd7, 32'h77, 3'd0}) begin
      n_err++;
      $display("FAIL full_last got %b %0d %h c=%0d want 1 7 77 0", we3, a3, wd3, count);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int writes;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr = 5'(i + 1);
      req_data = 32'h200 + 32'(i + 1);
      tick();
    end
    req_valid = 1'b0;
    hold = 1'b0;
    tick();
    n_vec++;
    if ({we3, count} !== {1'b1, 3'd3}) begin
      n_err++; $display("FAIL mid_pre got we=%b c=%0d want 1 3", we3, count);
    end
    a1 = 5'd2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({we3, count, req_ready, hit1} !== {1'b0, 3'd0, 2'b00}) begin
      n_err++;
      $display("FAIL mid_rst got we=%b c=%0d rdy=%b hit=%b want 0 0 0 0",
               we3, count, req_ready, hit1);
    end
    tick();
    rst_n = 1'b1;
    writes = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (we3 !== 1'b0) writes++;
    end
    n_vec++;
    if (writes !== 0) begin
      n_err++; $display("FAIL mid_nowr got %0d writes want 0", writes);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_fill_held();
    test_forward();
    test_bad_addr();
    test_full_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Write-side front end for the 8-entry register file: it buffers writeback requests from the datapath in a small FIFO and drains them, one per cycle, onto the register file's single write port (A3/WE3/WD3). It also reports whether a read address (A1/A2) has a write still pending in the queue, and forwards the youngest pending data so readers see the correct value. It sits between the writeback stage and the register file.

## Interface
- DEPTH, 4, FIFO entries (power of 2, >= 2)
- AW, 5, address width (matches A1/A2/A3)
- DW, 32, data width
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- REQ_VALID  in  1  write request valid
- REQ_READY  out  1  request accepted when VALID & READY at a rising edge
- REQ_ADDR  in  AW  destination register
- REQ_DATA  in  DW  write data
- HOLD  in  1  1 = do not drain the FIFO this cycle
- A3  out  AW  register file write address (registered)
- WE3  out  1  register file write enable (registered)
- WD3  out  DW  register file write data (registered)
- A1, A2  in  AW  read addresses, same values driven to the register file
- HIT1, HIT2  out  1  a pending write exists for A1 / A2 (combinational)
- FWD1, FWD2  out  DW  youngest pending data for A1 / A2; 0 when no hit
- COUNT  out  $clog2(DEPTH)+1  number of FIFO entries
- BADADDR  out  1  one-cycle pulse after a request with REQ_ADDR[4:3] != 0 is accepted

## Operation
- REQ_READY = RST_N & (COUNT < DEPTH); it does not consider a same-cycle pop.
- Accepting a request with REQ_ADDR[4:3] == 0 pushes {addr, data} at the tail.
- Accepting a request with REQ_ADDR[4:3] != 0 does the following:
  - the request is consumed but not enqueued;
  - BADADDR = 1 for the next cycle;
  - COUNT is unchanged.
- Drain: at each edge where HOLD = 0 and COUNT > 0, the head is popped into the output stage.
  - The output stage then holds WE3 = 1, A3 = head addr, WD3 = head data for exactly one cycle.
  - If no pop happens at an edge, WE3 = 0. A3 and WD3 keep their last values.
- Push and pop at the same edge: COUNT is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits and wrap naturally. Full is COUNT == DEPTH; empty is COUNT == 0.
- Lookup for A1 (A2 is identical and independent):
  - Candidates are the valid FIFO entries plus the output stage when WE3 = 1.
  - A candidate matches when its full AW-bit address equals A1.
  - Priority: the youngest FIFO entry (nearest the tail) wins over older entries, and any FIFO entry wins over the output stage.
  - Once the register file write edge has passed, the entry is no longer a candidate; the register file supplies the value.
- No bypass path: requests always pass through the FIFO.
- Reset (RST_N low, asynchronous):
  - COUNT = 0 and both pointers = 0;
  - WE3 = 0, A3 = 0, WD3 = 0;
  - BADADDR = 0, HIT1/2 = 0, FWD1/2 = 0, REQ_READY = 0.
  - Pending entries are discarded and never written, including on reset mid-drain.

## Timing
- Request accepted at edge k with HOLD = 0 and an empty FIFO:
  - popped at edge k+1;
  - WE3 = 1 from k+1 to k+2;
  - register file captures at edge k+2.
- Minimum latency is therefore 2 edges.
- Each HOLD cycle adds one cycle per queued entry. Drain throughput is 1 write per cycle.
- HIT and FWD settle combinationally in the same cycle as A1/A2 or queue state changes.
- BADADDR is high for the single cycle after the accepting edge.
- REQ_READY rises in the cycle after a pop makes COUNT < DEPTH.

## Test plan
- Single write:
  - Stimulus: reset, then request addr 3, data 0xDEADBEEF with HOLD = 0.
  - Required: the next cycle shows WE3 = 1, A3 = 3, WD3 = 0xDEADBEEF; after the following edge the register file RD1 for A1 = 3 is 0xDEADBEEF and WE3 = 0.
- Fill while held:
  - Stimulus: HOLD = 1, push addr 1..4 with data 0x10..0x40.
  - Required: COUNT = 4, REQ_READY = 0, WE3 = 0 throughout.
  - Then drop HOLD. Required: 4 consecutive cycles of WE3 = 1 with A3 = 1, 2, 3, 4 in order, then COUNT = 0.
- Forwarding:
  - Stimulus: HOLD = 1, push (5, 0x11) then (5, 0x22); set A1 = 5, A2 = 6.
  - Required: HIT1 = 1, FWD1 = 0x22, HIT2 = 0, FWD2 = 0.
  - Then release HOLD. Required: HIT1 stays 1 until the 0x22 write edge has passed.
- Bad address:
  - Stimulus: request addr 9.
  - Required: accepted, BADADDR = 1 for one cycle, COUNT unchanged, no WE3 pulse.
- Full with simultaneous pop:
  - Stimulus: COUNT = 4, drop HOLD with REQ_VALID = 1.
  - Required: REQ_READY = 0 on that edge, COUNT = 3 after it, then the request is accepted at the next edge.
- Reset mid-operation:
  - Stimulus: 3 entries pending and WE3 = 1, then assert RST_N = 0.
  - Required: WE3 = 0 and COUNT = 0 immediately; after release, no writes occur.
